seg7_scan_decoder: RTL



---
 rtl/seg7_pkg.sv | 25 ++
 rtl/seg7_scan_decoder_if.sv | 13 +
 rtl/seg7_pattern_decode.sv | 29 ++
 rtl/seg7_scan_decoder.sv | 118 +++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Segment patterns and decoded-digit type shared by the 7-segment encode and readback blocks.
// Segment order is a..g with a as the MSB.
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'h7E;
  localparam logic [6:0] SEG_1     = 7'h30;
  localparam logic [6:0] SEG_2     = 7'h6D;
  localparam logic [6:0] SEG_3     = 7'h79;
  localparam logic [6:0] SEG_4     = 7'h33;
  localparam logic [6:0] SEG_5     = 7'h5B;
  localparam logic [6:0] SEG_6     = 7'h5F;
  localparam logic [6:0] SEG_7     = 7'h70;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h7B;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  localparam logic [3:0] BCD_NONE  = 4'hF;

  typedef struct packed {
    logic [3:0] bcd;
    logic       blank;
    logic       err;
  } digit_t;

endpackage

// File: rtl/seg7_scan_decoder_if.sv
// Frame output bus of the scan decoder: valid/ready handshake plus the per-digit snapshot.
interface seg7_scan_decoder_if #(parameter int NUM_DIGITS = 4);

  logic                    out_valid;
  logic                    out_ready;
  logic [4*NUM_DIGITS-1:0] out_bcd;
  logic [NUM_DIGITS-1:0]   out_blank;
  logic [NUM_DIGITS-1:0]   out_err;

  modport master (output out_valid, out_bcd, out_blank, out_err, input out_ready);
  modport slave  (input out_valid, out_bcd, out_blank, out_err, output out_ready);

endinterface

// File: rtl/seg7_pattern_decode.sv
// Inverse 7-segment mapping: segment pattern to BCD, flagging dark and unrecognised patterns.
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [6:0] seg,
  output digit_t     dec
);

  always_comb begin
    dec.bcd   = BCD_NONE;
    dec.blank = 1'b0;
    dec.err   = 1'b0;
    case (seg)
      SEG_0:     dec.bcd = 4'd0;
      SEG_1:     dec.bcd = 4'd1;
      SEG_2:     dec.bcd = 4'd2;
      SEG_3:     dec.bcd = 4'd3;
      SEG_4:     dec.bcd = 4'd4;
      SEG_5:     dec.bcd = 4'd5;
      SEG_6:     dec.bcd = 4'd6;
      SEG_7:     dec.bcd = 4'd7;
      SEG_8:     dec.bcd = 4'd8;
      SEG_9:     dec.bcd = 4'd9;
      SEG_BLANK: dec.blank = 1'b1;
      default:   dec.err = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Captures a multiplexed 7-segment display bus, debounces each digit over scan visits
// and hands complete frames out over a valid/ready handshake.
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int STABLE_CNT = 3
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [6:0]            seg,
  input  logic [NUM_DIGITS-1:0] dig_en,
  seg7_scan_decoder_if.master   frame
);

  localparam int             CW      = $clog2(STABLE_CNT + 1);
  localparam logic [CW-1:0]  CNT_MAX = CW'(STABLE_CNT);

  typedef enum logic {COLLECT, PRESENT} state_t;

  logic [6:0]                   seg_q;
  logic [NUM_DIGITS-1:0]        en_q;
  logic                         one_hot;
  digit_t                       dec;
  digit_t [NUM_DIGITS-1:0]      work, work_nxt, snap;
  logic   [NUM_DIGITS-1:0]      captured, commit;
  state_t                       state, state_nxt;
  logic                         load, clear;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      seg_q <= '0;
      en_q  <= '0;
    end else begin
      seg_q <= seg;
      en_q  <= dig_en;
    end
  end

  assign one_hot = (en_q != '0) && ((en_q & (en_q - NUM_DIGITS'(1))) == '0);

  seg7_pattern_decode u_dec (.seg(seg_q), .dec(dec));

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_dig
    logic          hit, same, cap_r;
    logic [CW-1:0] cnt_r, cnt_nxt;
    digit_t        cand_r, work_r;

    assign hit  = one_hot & en_q[i];
    assign same = (dec == cand_r);

    always_comb begin
      cnt_nxt = cnt_r;
      if (hit) begin
        if (!same)                cnt_nxt = CW'(1);
        else if (cnt_r < CNT_MAX) cnt_nxt = cnt_r + CW'(1);
      end
    end

    // Saturated counters keep re-committing so a cleared digit recaptures on its next visit.
    assign commit[i]   = hit && (cnt_nxt == CNT_MAX);
    assign work_nxt[i] = commit[i] ? dec : work_r;
    assign work[i]     = work_r;
    assign captured[i] = cap_r;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        cand_r <= '0;
        cnt_r  <= '0;
        work_r <= '0;
        cap_r  <= 1'b0;
      end else begin
        if (hit) begin
          cand_r <= dec;
          cnt_r  <= cnt_nxt;
        end
        work_r <= work_nxt[i];
        if (commit[i])  cap_r <= 1'b1;
        else if (clear) cap_r <= 1'b0;
      end
    end

    assign frame.out_bcd[4*i +: 4] = snap[i].bcd;
    assign frame.out_blank[i]      = snap[i].blank;
    assign frame.out_err[i]        = snap[i].err;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= COLLECT;
    else          state <= state_nxt;
  end

  // Look through this cycle's commits so the frame is presented the cycle after the last commit.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    clear     = 1'b0;
    case (state)
      COLLECT: if (&(captured | commit)) begin
        load      = 1'b1;
        state_nxt = PRESENT;
      end
      PRESENT: if (frame.out_ready) begin
        clear     = 1'b1;
        state_nxt = COLLECT;
      end
      default: state_nxt = COLLECT;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  snap <= '0;
    else if (load) snap <= work_nxt;
  end

  assign frame.out_valid = (state == PRESENT);

endmodule
